// File: rtl/event_timestamp_capture.sv
// Timestamps rising edges of event_in as {epoch, cnt_q} into a FWFT FIFO; entry visible one cycle after the edge.
// ts_valid/ts_ready drain the FIFO; a capture that finds it full with no pop is dropped and sets sticky overflow.

module fifo_fwft #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [W-1:0]             wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  assign rd_vld = (level != '0);
  assign full   = (level == FULL_LVL);
  assign pop    = rd_vld & rd_rdy;
  // A pop frees the head slot this cycle, so a full FIFO can still take a write.
  assign wr_rdy = ~full | pop;
  assign push   = wr_vld & wr_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module event_timestamp_capture #(
  parameter int CNT_W   = 16,
  parameter int EPOCH_W = 16,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CNT_W-1:0]           cnt_q,
  input  logic                       cnt_rollover,
  input  logic                       event_in,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [EPOCH_W+CNT_W-1:0]   ts_data,
  output logic [EPOCH_W-1:0]         epoch,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  input  logic                       overflow_clr
);
  typedef struct packed {
    logic [EPOCH_W-1:0] epoch;
    logic [CNT_W-1:0]   cnt;
  } ts_t;

  logic event_d;
  logic capture;
  logic push_rdy;
  logic drop;
  ts_t  cap_dat;

  // Epoch advances on the same edge that cnt_q wraps, keeping {epoch, cnt_q} monotonic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch   <= '0;
      event_d <= 1'b0;
    end else begin
      event_d <= event_in;
      if (cnt_rollover) begin
        epoch <= epoch + EPOCH_W'(1);
      end
    end
  end

  assign capture     = event_in & ~event_d;
  assign cap_dat.epoch = epoch;
  assign cap_dat.cnt   = cnt_q;

  fifo_fwft #(
    .W     (EPOCH_W + CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (capture),
    .wr_rdy (push_rdy),
    .wr_dat (cap_dat),
    .rd_vld (ts_valid),
    .rd_rdy (ts_ready),
    .rd_dat (ts_data),
    .level  (fifo_level)
  );

  assign drop = capture & ~push_rdy;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end
endmodule
